sprite_render_engine: RTL and testbench

SPRITE_RENDER_ENGINE -- requirements
Module: sprite_render_engine

---
 rtl/sprite_render_engine_pkg.sv | 20 ++
 rtl/raster_scanner.sv | 44 ++++
 rtl/sprite_render_engine.sv | 187 ++++++++++++++++++
 tb/tb_sprite_render_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_render_engine_pkg.sv
// Shared constants and FSM encoding for the sprite renderer.
package sprite_render_engine_pkg;

  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned SCR_W_DEF = 160;
  localparam int unsigned SCR_H_DEF = 120;

  // 5x5 sprite bitmap, bit index r*5+c
  localparam logic [24:0] SPR_MASK_DEF = 25'h0476DC4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAW  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/raster_scanner.sv
// Row-major rectangle scanner; steps one position per accepted advance.
module raster_scanner
  import sprite_render_engine_pkg::*;
#(
  parameter int unsigned CW = X_W,
  parameter int unsigned RW = Y_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  input  logic [CW-1:0] col_last,
  input  logic [RW-1:0] row_last,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          active
);

  // active drops once the final position has been handed out
  always_ff @(posedge clock) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      active <= 1'b0;
    end else if (start) begin
      col    <= '0;
      row    <= '0;
      active <= 1'b1;
    end else if (advance && active) begin
      if (col == col_last) begin
        col <= '0;
        if (row == row_last) begin
          row    <= '0;
          active <= 1'b0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_render_engine.sv
// Frame renderer: optional full-screen clear, then one masked, clipped sprite per valid slot.
module sprite_render_engine
  import sprite_render_engine_pkg::*;
#(
  parameter int unsigned NUM_OBJ  = 8,
  parameter int unsigned SPR_W    = 5,
  parameter int unsigned SPR_H    = 5,
  parameter int unsigned SCR_W    = SCR_W_DEF,
  parameter int unsigned SCR_H    = SCR_H_DEF,
  parameter int unsigned COLOUR_W = 3,
  parameter logic [SPR_W*SPR_H-1:0] SPR_MASK = SPR_MASK_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear_en,
  input  logic [COLOUR_W-1:0]          bg_colour,
  input  logic [NUM_OBJ-1:0]           obj_valid,
  input  logic [NUM_OBJ*X_W-1:0]       obj_x,
  input  logic [NUM_OBJ*Y_W-1:0]       obj_y,
  input  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour,
  input  logic                         plot_ready,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_OBJ)-1:0]   obj_index
);

  localparam int unsigned OI_W = $clog2(NUM_OBJ);
  localparam int unsigned MI_W = $clog2(SPR_W * SPR_H);
  localparam int unsigned O_W  = X_W + 1;
  localparam int unsigned P_W  = X_W + 2;

  state_t                        state;
  logic [NUM_OBJ-1:0]            snap_valid;
  logic [NUM_OBJ*X_W-1:0]        snap_x;
  logic [NUM_OBJ*Y_W-1:0]        snap_y;
  logic [NUM_OBJ*COLOUR_W-1:0]   snap_colour;
  logic [COLOUR_W-1:0]           snap_bg;
  logic signed [O_W-1:0]         ox;
  logic signed [O_W-1:0]         oy;

  logic [X_W-1:0]                scan_col;
  logic [Y_W-1:0]                scan_row;
  logic                          scan_active;
  logic                          scan_start;
  logic                          scan_advance;
  logic                          clear_pass;
  logic                          take;
  logic                          last_obj;

  logic [X_W-1:0]                slot_x;
  logic [Y_W-1:0]                slot_y;
  logic [COLOUR_W-1:0]           slot_colour;
  logic signed [P_W-1:0]         px_s;
  logic signed [P_W-1:0]         py_s;
  logic [MI_W-1:0]               mask_idx;
  logic                          pix_vis;
  logic [X_W-1:0]                pix_x;
  logic [Y_W-1:0]                pix_y;
  logic [COLOUR_W-1:0]           pix_colour;

  assign slot_x      = snap_x[32'(obj_index) * X_W +: X_W];
  assign slot_y      = snap_y[32'(obj_index) * Y_W +: Y_W];
  assign slot_colour = snap_colour[32'(obj_index) * COLOUR_W +: COLOUR_W];
  assign last_obj    = (obj_index == OI_W'(NUM_OBJ - 1));

  // Output slot is free when it holds nothing or its pixel is being accepted
  assign take         = !plot || plot_ready;
  assign clear_pass   = (state == S_CLEAR);
  assign scan_advance = (state == S_CLEAR || state == S_DRAW) && take;
  assign scan_start   = (state == S_IDLE && start && clear_en) ||
                        (state == S_LOAD && snap_valid[obj_index]);

  raster_scanner #(
    .CW (X_W),
    .RW (Y_W)
  ) u_scanner (
    .clock    (clock),
    .reset    (reset),
    .start    (scan_start),
    .advance  (scan_advance),
    .col_last (clear_pass ? X_W'(SCR_W - 1) : X_W'(SPR_W - 1)),
    .row_last (clear_pass ? Y_W'(SCR_H - 1) : Y_W'(SPR_H - 1)),
    .col      (scan_col),
    .row      (scan_row),
    .active   (scan_active)
  );

  // Pixel for the current scan position: mask lookup and screen clipping
  always_comb begin
    px_s     = $signed({ox[O_W-1], ox}) + $signed(P_W'(scan_col));
    py_s     = $signed({oy[O_W-1], oy}) + $signed(P_W'(scan_row));
    mask_idx = MI_W'(32'(scan_row) * SPR_W + 32'(scan_col));
    if (clear_pass) begin
      pix_vis    = 1'b1;
      pix_x      = scan_col;
      pix_y      = scan_row;
      pix_colour = snap_bg;
    end else begin
      pix_vis    = SPR_MASK[mask_idx] &&
                   !px_s[P_W-1] && (px_s[P_W-2:0] < (P_W-1)'(SCR_W)) &&
                   !py_s[P_W-1] && (py_s[P_W-2:0] < (P_W-1)'(SCR_H));
      pix_x      = px_s[X_W-1:0];
      pix_y      = py_s[Y_W-1:0];
      pix_colour = slot_colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      obj_index   <= '0;
      ox          <= '0;
      oy          <= '0;
      snap_valid  <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_colour <= '0;
      snap_bg     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snap_valid  <= obj_valid;
            snap_x      <= obj_x;
            snap_y      <= obj_y;
            snap_colour <= obj_colour;
            snap_bg     <= bg_colour;
            busy        <= 1'b1;
            obj_index   <= '0;
            state       <= clear_en ? S_CLEAR : S_LOAD;
          end
        end
        S_CLEAR, S_DRAW: begin
          if (take) begin
            if (scan_active) begin
              plot   <= pix_vis;
              x      <= pix_x;
              y      <= pix_y;
              colour <= pix_colour;
            end else begin
              plot <= 1'b0;
              if (state == S_CLEAR) begin
                obj_index <= '0;
                state     <= S_LOAD;
              end else if (last_obj) begin
                state <= S_FIN;
              end else begin
                obj_index <= obj_index + OI_W'(1);
                state     <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (snap_valid[obj_index]) begin
            ox    <= {1'b0, slot_x} - O_W'(SPR_W / 2);
            oy    <= O_W'(slot_y) - O_W'(SPR_H / 2);
            state <= S_DRAW;
          end else if (last_obj) begin
            state <= S_FIN;
          end else begin
            obj_index <= obj_index + OI_W'(1);
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_render_engine.sv
// Scoreboard bench for sprite_render_engine with a pixel-list reference model.
module tb_sprite_render_engine;

  localparam int NUM_OBJ = 8;
  localparam int SPR_W   = 5;
  localparam int SPR_H   = 5;
  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam logic [24:0] MASK = 25'h0476DC4;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        clear_en;
  logic [2:0]  bg_colour;
  logic [7:0]  obj_valid;
  logic [63:0] obj_x;
  logic [55:0] obj_y;
  logic [23:0] obj_colour;
  logic        plot_ready;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_col;
  logic        plot;
  logic        busy;
  logic        done;
  logic [2:0]  obj_index;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   frame_plots = 0;
  int   ready_mode = 0;
  int   st;
  bit   sb_en = 0;
  bit   hold_pend = 0;
  logic [18:0] hold_val;
  logic [63:0] rxs;
  logic [55:0] rys;
  logic [23:0] rcs;
  pix_t exp_q[$];
  int   frame_q[$];

  sprite_render_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .clear_en   (clear_en),
    .bg_colour  (bg_colour),
    .obj_valid  (obj_valid),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_colour (obj_colour),
    .plot_ready (plot_ready),
    .x          (pix_x),
    .y          (pix_y),
    .colour     (pix_col),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .obj_index  (obj_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink readiness: 0 always ready, 1 coin flip, 2 two-ready/three-stalled, 3 mostly ready
  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       plot_ready = 1'($urandom_range(0, 1));
        2:       plot_ready = ((cyc % 5) < 2);
        3:       plot_ready = ($urandom_range(0, 7) != 0);
        default: plot_ready = 1'b1;
      endcase
    end
  end

  // Reference model: the ordered list of pixels a frame must emit
  task automatic model(input bit clr, input logic [2:0] bg, input logic [7:0] v,
                       input logic [63:0] xs, input logic [55:0] ys, input logic [23:0] cs);
    int n;
    pix_t p;
    n = 0;
    if (clr) begin
      for (int yy = 0; yy < SCR_H; yy++) begin
        for (int xx = 0; xx < SCR_W; xx++) begin
          p.x = 8'(xx); p.y = 7'(yy); p.c = bg;
          exp_q.push_back(p);
          n++;
        end
      end
    end
    for (int s = 0; s < NUM_OBJ; s++) begin
      if (v[s]) begin
        for (int r = 0; r < SPR_H; r++) begin
          for (int c = 0; c < SPR_W; c++) begin
            int px;
            int py;
            px = int'(xs[8*s +: 8]) - SPR_W / 2 + c;
            py = int'(ys[7*s +: 7]) - SPR_H / 2 + r;
            if (MASK[r*SPR_W + c] && px >= 0 && px < SCR_W && py >= 0 && py < SCR_H) begin
              p.x = 8'(px); p.y = 7'(py); p.c = cs[3*s +: 3];
              exp_q.push_back(p);
              n++;
            end
          end
        end
      end
    end
    frame_q.push_back(n);
  endtask

  // Monitor: consume handshakes and frame ends against the scoreboard
  always @(negedge clock) begin
    pix_t e;
    int n;
    if (sb_en) begin
      if (hold_pend) chk("stall_hold", {plot, pix_x, pix_y, pix_col}, 32'(hold_val));
      if (plot && plot_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_plot_x", pix_x, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pix_x", pix_x, e.x);
          chk("pix_y", pix_y, e.y);
          chk("pix_colour", pix_col, e.c);
          frame_plots++;
        end
      end
      if (done) begin
        done_count++;
        last_done_cyc = cyc;
        chk("busy_low_at_done", busy, 0);
        if (frame_q.size() == 0) begin
          chk("unexpected_done", done_count, 0);
        end else begin
          n = frame_q.pop_front();
          chk("frame_plot_count", frame_plots, n);
        end
        frame_plots = 0;
      end
      hold_pend = plot && !plot_ready;
      hold_val  = {plot, pix_x, pix_y, pix_col};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic run_frame(input bit clr, input logic [2:0] bg, input logic [7:0] v,
                           input logic [63:0] xs, input logic [55:0] ys, input logic [23:0] cs,
                           input int budget, input bit disturb, output int st_cyc);
    int d0;
    int i;
    model(clr, bg, v, xs, ys, cs);
    @(posedge clock);
    #1;
    clear_en = clr; bg_colour = bg; obj_valid = v;
    obj_x = xs; obj_y = ys; obj_colour = cs;
    start = 1'b1;
    st_cyc = cyc;
    d0 = done_count;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (disturb) begin
      repeat (4) @(posedge clock);
      #1;
      obj_x = ~xs; obj_y = ~ys; obj_colour = ~cs; obj_valid = ~v;
      clear_en = 1'b1; bg_colour = ~bg; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    i = 0;
    while (done_count == d0 && i < budget) begin
      @(posedge clock);
      i++;
    end
    if (done_count == d0) chk("done_timeout", done_count, d0 + 1);
    repeat (3) @(posedge clock);
    #1;
    chk("done_once", done_count - d0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; clear_en = 1'b0; bg_colour = '0;
    obj_valid = '0; obj_x = '0; obj_y = '0; obj_colour = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_busy_with_start", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_colour", pix_col, 0);
    chk("rst_obj_index", obj_index, 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_busy", busy, 0);
    sb_en = 1'b1;

    // Empty frame: no plots, fixed latency to done
    run_frame(0, 3'd0, 8'h00, 64'd0, 56'd0, 24'd0, 200, 0, st);
    chk("empty_done_latency", last_done_cyc - st, NUM_OBJ + 2);

    // Single centred sprite
    rxs = '0; rys = '0; rcs = '0;
    rxs[7:0] = 8'd79; rys[6:0] = 7'd59; rcs[2:0] = 3'b110;
    run_frame(0, 3'd0, 8'h01, rxs, rys, rcs, 2000, 0, st);

    // Top-left corner clip
    rxs[7:0] = 8'd0; rys[6:0] = 7'd0; rcs[2:0] = 3'b011;
    run_frame(0, 3'd0, 8'h01, rxs, rys, rcs, 2000, 0, st);

    // Edge clipping on every side with a periodic 3-cycle stall
    ready_mode = 2;
    rxs = '0; rys = '0; rcs = 24'o76543210;
    rxs[15:8]  = 8'd159; rys[13:7]  = 7'd119;
    rxs[23:16] = 8'd161; rys[20:14] = 7'd60;
    rxs[31:24] = 8'd80;  rys[27:21] = 7'd121;
    rxs[39:32] = 8'd255; rys[34:28] = 7'd127;
    rxs[47:40] = 8'd2;   rys[41:35] = 7'd2;
    rxs[55:48] = 8'd158; rys[48:42] = 7'd1;
    run_frame(0, 3'd0, 8'b0111_1110, rxs, rys, rcs, 4000, 0, st);

    // Sparse slots, inputs and start disturbed mid-frame
    ready_mode = 1;
    rxs = '0; rys = '0; rcs = '0;
    rxs[7:0] = 8'd40;   rys[6:0] = 7'd30;   rcs[2:0] = 3'b011;
    rxs[63:56] = 8'd120; rys[55:49] = 7'd100; rcs[23:21] = 3'b101;
    run_frame(0, 3'd0, 8'b1000_0001, rxs, rys, rcs, 4000, 1, st);

    // Full clear pass
    ready_mode = 0;
    run_frame(1, 3'b000, 8'h00, 64'd0, 56'd0, 24'd0, 30000, 0, st);

    // Reset in the middle of a clear pass, with start also high
    sb_en = 1'b0;
    @(posedge clock);
    #1;
    clear_en = 1'b1; bg_colour = 3'b010; obj_valid = '0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (150) @(posedge clock);
    #1;
    chk("mid_clear_plot", plot, 1);
    reset = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_plot", plot, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_x", pix_x, 0);
    chk("midrst_y", pix_y, 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_plot", plot, 0);
    exp_q.delete(); frame_q.delete(); frame_plots = 0;
    sb_en = 1'b1;

    // Full frame after reset: clear plus objects, mostly-ready sink
    ready_mode = 3;
    rxs = '0; rys = '0; rcs = 24'o12345670;
    rxs[7:0] = 8'd10;   rys[6:0] = 7'd10;
    rxs[23:16] = 8'd157; rys[20:14] = 7'd118;
    rxs[47:40] = 8'd1;   rys[41:35] = 7'd119;
    run_frame(1, 3'b101, 8'b0010_0101, rxs, rys, rcs, 40000, 0, st);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      ready_mode = (f % 2 == 0) ? 1 : 2;
      for (int s = 0; s < NUM_OBJ; s++) begin
        rxs[8*s +: 8] = 8'($urandom_range(0, 165));
        rys[7*s +: 7] = 7'($urandom_range(0, 125));
        rcs[3*s +: 3] = 3'($urandom_range(0, 7));
      end
      run_frame(0, 3'd0, 8'($urandom), rxs, rys, rcs, 6000, 0, st);
    end

    chk("leftover_pixels", exp_q.size(), 0);
    chk("leftover_frames", frame_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
